// File: rtl/pll_pkg.sv
// pll_pkg: shared state encoding and counter-width helper for the loop filter sequencer
package pll_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, FLUSH, ACQUIRE, TRACK} seq_state_t;
  function automatic int cnt_width(int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/window_event_counter.sv
// window_event_counter: fixed-length observation window with a saturating event count
module window_event_counter
  import pll_pkg::*;
#(
  parameter int WINDOW_LEN = 256
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               clear,
  input  logic                               run,
  input  logic                               evt,
  output logic                               window_done,
  output logic [cnt_width(WINDOW_LEN)-1:0]   count
);
  localparam int PW = cnt_width(WINDOW_LEN - 1);
  localparam int CW = cnt_width(WINDOW_LEN);
  localparam logic [PW-1:0] LAST = PW'(WINDOW_LEN - 1);
  localparam logic [CW-1:0] MAX = '1;
  logic [PW-1:0] cyc;
  logic [CW-1:0] acc;
  assign window_done = run && cyc == LAST;
  // count already includes this cycle's event so the last cycle is judged in full
  assign count = (evt && acc != MAX) ? acc + CW'(1) : acc;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      cyc <= '0;
      acc <= '0;
    end else if (clear) begin
      cyc <= '0;
      acc <= '0;
    end else if (run) begin
      cyc <= window_done ? '0 : cyc + PW'(1);
      acc <= window_done ? '0 : count;
    end
endmodule

// File: rtl/loop_filter_sequencer.sv
// loop_filter_sequencer: flush/acquire/track sequencing of the PLL loop filter with windowed lock detection
module loop_filter_sequencer
  import pll_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 4,
  parameter int WINDOW_LEN    = 256,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_WINDOWS  = 4,
  parameter int UNLOCK_THRESH = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       early_i,
  input  logic       late_i,
  input  logic       positiveShift_i,
  input  logic       negativeShift_i,
  output logic       filterReset_o,
  output logic       forwarding_o,
  output logic       slowing_o,
  output logic       fastAdvance_o,
  output logic       fastRetard_o,
  output logic       locked_o,
  output logic [1:0] state_o
);
  localparam int FW = cnt_width(FLUSH_CYCLES - 1);
  localparam int QW = cnt_width(LOCK_WINDOWS);
  localparam int CW = cnt_width(WINDOW_LEN);
  localparam logic [FW-1:0] FLAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [QW-1:0] LW = QW'(LOCK_WINDOWS);
  localparam logic [CW-1:0] LT = CW'(LOCK_THRESH);
  localparam logic [CW-1:0] UT = CW'(UNLOCK_THRESH);
  seq_state_t state, nxt;
  logic [FW-1:0] flush_cnt;
  logic [QW-1:0] quiet, quiet_nxt;
  logic [CW-1:0] count;
  logic adv, ret, shift, acq, trk, evt, done;
  // simultaneous opposite pulses cancel
  assign adv = early_i & ~late_i;
  assign ret = late_i & ~early_i;
  assign shift = positiveShift_i ^ negativeShift_i;
  assign acq = state == ACQUIRE;
  assign trk = state == TRACK;
  assign evt = acq ? (adv | ret) : (trk & shift);
  window_event_counter #(.WINDOW_LEN(WINDOW_LEN)) u_win (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear       (!(acq || trk)),
    .run         (acq || trk),
    .evt         (evt),
    .window_done (done),
    .count       (count)
  );
  always_comb begin
    quiet_nxt = (count <= LT) ? quiet + QW'(1) : '0;
    nxt = state;
    case (state)
      IDLE:    nxt = FLUSH;
      FLUSH:   nxt = (flush_cnt == FLAST) ? ACQUIRE : FLUSH;
      ACQUIRE: nxt = (done && quiet_nxt == LW) ? TRACK : ACQUIRE;
      TRACK:   nxt = (done && count > UT) ? FLUSH : TRACK;
      default: nxt = IDLE;
    endcase
    if (!enable_i) nxt = IDLE;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state         <= IDLE;
      flush_cnt     <= '0;
      quiet         <= '0;
      filterReset_o <= 1'b0;
      locked_o      <= 1'b0;
      fastAdvance_o <= 1'b0;
      fastRetard_o  <= 1'b0;
      forwarding_o  <= 1'b0;
      slowing_o     <= 1'b0;
    end else begin
      state         <= nxt;
      flush_cnt     <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      quiet         <= !acq ? '0 : done ? quiet_nxt : quiet;
      filterReset_o <= nxt == ACQUIRE || nxt == TRACK;
      locked_o      <= nxt == TRACK;
      fastAdvance_o <= acq & adv;
      fastRetard_o  <= acq & ret;
      forwarding_o  <= trk & adv;
      slowing_o     <= trk & ret;
    end
  assign state_o = state;
endmodule
